serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single `full_adder` instance over WIDTH cycles to add two WIDTH-bit operands. It shifts one operand bit pair per clock through the full adder, holding the carry in a flop between cycles. It sits between a producer and a consumer, each connected through a valid/ready handshake. Area matters more than latency in this block.

## Interface

- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, c_in (and sub) are valid.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in for the LSB.
- sub  input  1  subtract when high; present only with SERIAL_ADDER_SUB_EN.
- out_valid  output  1  sum and c_out hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, LSB at bit 0.
- c_out  output  1  carry out of the MSB.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - An accept occurs when in_valid and in_ready are both high at a rising edge.
  - On accept, a and b go into shift registers, carry loads c_in, bit counter clears to 0, and the state moves to RUN.
- RUN:
  - Each cycle, a_sh[0], b_sh[0] and carry drive the full_adder.
  - The adder's sum bit shifts into sum_sh at the MSB (right shift). a_sh and b_sh shift right. carry takes the adder's c_out. The counter increments.
  - After the edge that processes bit WIDTH-1, the state moves to DONE.
- DONE:
  - out_valid=1. sum=sum_sh and c_out=carry, held stable.
  - On out_valid and out_ready at an edge, the state moves to IDLE.
  - in_valid is ignored in this state.
- Arithmetic is unsigned mod 2^WIDTH, and {c_out, sum} = a + b + c_in exactly.
- The counter is $clog2(WIDTH)+1 bits, so it cannot wrap before reaching WIDTH-1. WIDTH=1 takes one RUN cycle.
- sum is only meaningful while out_valid is high. During RUN it shows partial shift contents.
- Reset, including in the middle of RUN or DONE:
  - The operation is dropped and never produces out_valid.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, all internal registers 0.

## Timing

- Accept at edge 0. Bits 0..WIDTH-1 are processed at edges 1..WIDTH. out_valid rises after edge WIDTH.
- Latency from accept to out_valid is WIDTH cycles.
- With out_ready held high:
  - DONE lasts one cycle, and the state returns to IDLE after edge WIDTH+1.
  - The next accept happens no earlier than edge WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- in_ready and out_valid are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- out_ready may be held low indefinitely. Outputs stay frozen.

## Configuration

- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is captured at accept.
  - When sub=1, b is captured inverted, carry initialises to 1, and c_in is ignored. The result is {c_out, sum} = a + ~b + 1, where c_out=1 means no borrow.
  - When sub=0, behaviour matches the undefined case.
- SERIAL_ADDER_SUB_EN undefined: there is no sub port and the block only adds.

## Structure

- serial_adder_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE=2'd0, RUN=2'd1, DONE=2'd2}.
  - Nothing WIDTH-dependent; WIDTH stays a module parameter.
- The only sub-module is the existing full_adder, instanced once with ports a, b, c_in, sum, c_out.
- Everything else (FSM, shift registers, counter, carry flop) is inline in serial_adder_ctrl.

## Test plan

All scenarios use WIDTH=8.
- Reset, then a=0x00, b=0x00, c_in=0: out_valid rises 8 cycles after accept with sum=0x00, c_out=0; after reset, in_ready=1 and out_valid=0.
- a=0xFF, b=0x01, c_in=0 (full ripple) -> sum=0x00, c_out=1. a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1.
- Backpressure, a=0x3C, b=0x41, c_in=0:
  - Hold out_ready=0 for 5 cycles after out_valid, while in_valid stays high with new operands.
  - Required: sum=0x7D, c_out=0 held stable, in_ready=0, and no new accept.
- Assert rst at the 3rd RUN cycle: out_valid never rises. A following operation 0x12+0x34 -> sum=0x46, c_out=0.
- Back-to-back, with in_valid and out_ready held high: accepts occur every 10 cycles, and each result matches a+b+c_in. Check 0x80+0x80, c_in=0 -> sum=0x00, c_out=1.
- With SERIAL_ADDER_SUB_EN, sub=1:
  - 0x10-0x01 -> sum=0x0F, c_out=1.
  - 0x00-0x01 -> sum=0xFF, c_out=0.
  - c_in=1 has no effect on either result.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding for the bit-serial adder controller
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder, the only arithmetic element of the serial adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder behind valid/ready handshakes; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] b_ld;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_ld;
    logic             fa_s;
    logic             fa_c;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    // subtract as a + ~b + 1: invert b on capture and force the initial carry
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub | c_in;
`else
    assign b_ld = b;
    assign c_ld = c_in;
`endif

    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = sum_sh;
    assign c_out     = carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_s),
        .c_out (fa_c)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: accept in IDLE, count WIDTH bits in RUN, wait for the consumer in DONE
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (in_valid  ? RUN  : IDLE) :
                  (state == RUN)  ? (last      ? DONE : RUN)  :
                  (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end

    // datapath: load operands on accept, then shift one bit pair per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the serial adder against an arithmetic model
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       c_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;
    int t_prev   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one operation: accept, expect result after 8 cycles, hold out_ready low for hold cycles
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input logic sv, input int hold);
        logic [8:0] exp;
        int n;
        exp = sv ? ({1'b0, av} + {1'b0, ~bv} + 9'd1) : ({1'b0, av} + {1'b0, bv} + 9'(ci));
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        c_in      = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = sv;
`endif
        out_ready = (hold == 0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        t_acc = cyc;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            c_in = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'd8);
        check("sum", 32'(sum), 32'(exp[7:0]));
        check("c_out", 32'(c_out), 32'(exp[8]));
        for (int i = 0; i < hold; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(exp[7:0]));
            check("hold_c_out", 32'(c_out), 32'(exp[8]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        run_op(8'h3C, 8'h41, 1'b0, 1'b0, 5);

        in_valid = 1'b1;
        a = 8'h77;
        b = 8'h11;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrun_out_valid", 32'(out_valid), 32'd0);
        check("midrun_in_ready", 32'(in_ready), 32'd1);
        check("midrun_sum", 32'(sum), 32'd0);
        check("midrun_c_out", 32'(c_out), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("dropped_out_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
        t_prev = t_acc;
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);
            check("b2b_period", 32'(t_acc - t_prev), 32'd10);
            t_prev = t_acc;
        end

        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b1, 1'b1, 0);
        for (int i = 0; i < 10; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
`endif

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
